// File: rtl/pong_pkg.sv
// Shared definitions for the pong display: screen limits, coordinate type and
// the button debouncer state encoding.
package pong_pkg;

  localparam int X_MAX       = 639;
  localparam int Y_MAX       = 479;
  localparam int REFRESH_ROW = 481;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    CHK_HI = 2'd1,
    S_HI   = 2'd2,
    CHK_LO = 2'd3
  } deb_state_t;

  // Accepted button level implied by a debouncer state.
  function automatic logic deb_level(input deb_state_t s);
    return (s == S_HI) || (s == CHK_LO);
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debounce FSM.
// The FSM state is the only output; the accepted level is decoded with deb_level().
module pad_debounce
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_btn,
  output logic [1:0] o_state
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  deb_state_t    r_state;
  logic          w_sync;

  assign w_sync  = r_sync[1];
  assign o_state = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_state <= S_LO;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      case (r_state)
        S_LO: begin
          if (w_sync) begin
            r_state <= CHK_HI;
            r_cnt   <= '0;
          end
        end
        CHK_HI: begin
          if (!w_sync)                r_state <= S_LO;
          else if (r_cnt == CNT_LAST) r_state <= S_HI;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        S_HI: begin
          if (!w_sync) begin
            r_state <= CHK_LO;
            r_cnt   <= '0;
          end
        end
        CHK_LO: begin
          if (w_sync)                 r_state <= S_HI;
          else if (r_cnt == CNT_LAST) r_state <= S_LO;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= S_LO;
      endcase
    end
  end

endmodule

// File: rtl/pad_ctrl.sv
// Player paddle: debounced up/down buttons move the paddle once per frame,
// clamped to the screen. Optional acceleration is enabled by PAD_ACCEL_EN.
module pad_ctrl #(
  parameter int PAD_X_LEFT      = 20,
  parameter int PAD_WIDTH       = 10,
  parameter int PAD_HEIGHT      = 80,
  parameter int PAD_Y_INIT      = 200,
  parameter int PAD_STEP        = 4,
  parameter int PAD_STEP_MAX    = 12,
  parameter int Y_MAX           = 479,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] pad_t,
  output logic [9:0] pad_b,
  output logic [9:0] pad_l,
  output logic [9:0] pad_r,
  output logic       pad_on
);
  import pong_pkg::*;

  localparam logic [10:0] Y_LIM = 11'(Y_MAX + 1 - PAD_HEIGHT);

  logic [1:0]  w_up_state, w_dn_state;
  logic        w_up_lvl, w_dn_lvl, w_up_only, w_dn_only;
  logic        w_tick_cond, w_frame_tick;
  logic [10:0] w_step, w_y_ext, w_y_up, w_y_dn_raw, w_y_dn;
  logic [9:0]  r_pad_y;
  logic        r_tick_cond;

  pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk(clk), .reset_n(reset_n), .i_btn(btn_up), .o_state(w_up_state)
  );
  pad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk(clk), .reset_n(reset_n), .i_btn(btn_down), .o_state(w_dn_state)
  );

  assign w_up_lvl  = deb_level(deb_state_t'(w_up_state));
  assign w_dn_lvl  = deb_level(deb_state_t'(w_dn_state));
  assign w_up_only = w_up_lvl & ~w_dn_lvl;
  assign w_dn_only = w_dn_lvl & ~w_up_lvl;

  // The refresh-row condition lasts a whole pixel, so only its rising edge counts.
  assign w_tick_cond  = (y == 10'(REFRESH_ROW)) && (x == 10'd0);
  assign w_frame_tick = w_tick_cond & ~r_tick_cond;

`ifdef PAD_ACCEL_EN
  logic [10:0] r_step;
  logic [2:0]  r_acc_cnt;
  logic        r_dir;

  // Any break in a single-direction hold restarts the ramp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step    <= 11'(PAD_STEP);
      r_acc_cnt <= '0;
      r_dir     <= 1'b0;
    end else if (!(w_up_only || w_dn_only) || (w_dn_only != r_dir)) begin
      r_step    <= 11'(PAD_STEP);
      r_acc_cnt <= '0;
      r_dir     <= w_dn_only;
    end else if (w_frame_tick) begin
      r_acc_cnt <= r_acc_cnt + 3'd1;
      if (r_acc_cnt == 3'd7 && r_step < 11'(PAD_STEP_MAX))
        r_step <= r_step + 11'd1;
    end
  end

  assign w_step = r_step;
`else
  assign w_step = 11'(PAD_STEP);
`endif

  assign w_y_ext    = {1'b0, r_pad_y};
  assign w_y_up     = (w_y_ext < w_step) ? 11'd0 : (w_y_ext - w_step);
  assign w_y_dn_raw = w_y_ext + w_step;
  assign w_y_dn     = (w_y_dn_raw > Y_LIM) ? Y_LIM : w_y_dn_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pad_y     <= 10'(PAD_Y_INIT);
      r_tick_cond <= 1'b0;
    end else begin
      r_tick_cond <= w_tick_cond;
      if (w_frame_tick) begin
        if (w_up_only)      r_pad_y <= w_y_up[9:0];
        else if (w_dn_only) r_pad_y <= w_y_dn[9:0];
      end
    end
  end

  assign pad_t  = r_pad_y;
  assign pad_b  = r_pad_y + 10'(PAD_HEIGHT - 1);
  assign pad_l  = 10'(PAD_X_LEFT);
  assign pad_r  = 10'(PAD_X_LEFT + PAD_WIDTH - 1);
  assign pad_on = (x >= pad_l) && (x <= pad_r) && (y >= pad_t) && (y <= pad_b);

endmodule

// File: tb/tb_pad_ctrl.sv
// Bench for pad_ctrl with a 4-cycle debounce and a compressed frame scan.
// Define PAD_ACCEL_EN on both RTL and bench to exercise acceleration.
module tb_pad_ctrl;

  localparam int STEP = 4, STEP_MAX = 12, LIM = 400, H = 80, XL = 20, W = 10;

  logic       clk = 1'b0;
  logic       reset_n, btn_up, btn_down, pad_on;
  logic [9:0] x, y, pad_t, pad_b, pad_l, pad_r;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_y = 200;
  int run_n = 0;
  int run_dir = 0;
  int mb_up = 0, mb_dn = 0;

  always #5 clk = ~clk;

  pad_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .x(x), .y(y), .pad_t(pad_t), .pad_b(pad_b), .pad_l(pad_l), .pad_r(pad_r),
    .pad_on(pad_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bounds(input string tag);
    check({tag, "_t"}, {22'd0, pad_t}, m_y);
    check({tag, "_b"}, {22'd0, pad_b}, m_y + H - 1);
    check({tag, "_l"}, {22'd0, pad_l}, XL);
    check({tag, "_r"}, {22'd0, pad_r}, XL + W - 1);
  endtask

  function automatic int model_step();
`ifdef PAD_ACCEL_EN
    int s;
    s = STEP + run_n / 8;
    return (s > STEP_MAX) ? STEP_MAX : s;
`else
    return STEP;
`endif
  endfunction

  task automatic model_frame();
    int s;
    if (mb_up != mb_dn) begin
      s = model_step();
      if (mb_up != 0) m_y = (m_y < s) ? 0 : m_y - s;
      else            m_y = (m_y + s > LIM) ? LIM : m_y + s;
      run_n++;
    end
  endtask

  task automatic set_btn(input int u, input int d);
    if (u == d) run_n = 0;
    else begin
      if (d != run_dir) run_n = 0;
      run_dir = d;
    end
    mb_up = u;
    mb_dn = d;
    @(negedge clk);
    btn_up   = u[0];
    btn_down = d[0];
    repeat (12) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    y = 10'd481; x = 10'd0;
    repeat (3) @(negedge clk);
    x = 10'd1;
    repeat (2) @(negedge clk);
    y = 10'd0; x = 10'd0;
    repeat (3) @(negedge clk);
    model_frame();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; x = '0; y = '0;
    mb_up = 0; mb_dn = 0; run_n = 0; run_dir = 0; m_y = 200;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pon(input string tag, input int px, input int py);
    int e;
    @(negedge clk);
    x = px[9:0]; y = py[9:0];
    #1;
    e = (px >= XL && px <= XL + W - 1 && py >= m_y && py <= m_y + H - 1) ? 1 : 0;
    check(tag, {31'd0, pad_on}, e);
  endtask

  initial begin
    int nf, u, d, px, py;
    reset_n = 1'b1; btn_up = 1'b0; btn_down = 1'b0; x = '0; y = '0;

    // reset values and hit test
    do_reset();
    check("rst_t", {22'd0, pad_t}, 200);
    check("rst_b", {22'd0, pad_b}, 279);
    check("rst_l", {22'd0, pad_l}, 20);
    check("rst_r", {22'd0, pad_r}, 29);
    pon("on_25_240", 25, 240);
    check("on_25_240_c", {31'd0, pad_on}, 1);
    pon("off_30_240", 30, 240);
    check("off_30_240_c", {31'd0, pad_on}, 0);

    // short bounces must be rejected
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); btn_down = ~i[0];
      @(negedge clk);
    end
    @(negedge clk); btn_down = 1'b0;
    repeat (10) @(negedge clk);
    frame();
    check("bounce_t", {22'd0, pad_t}, 200);

    set_btn(0, 1);
    frame();
    check("down1_t", {22'd0, pad_t}, 204);
    repeat (3) frame();
    check("down4_t", {22'd0, pad_t}, 216);
    check_bounds("down4");

    // up hold into the top edge
    set_btn(1, 0);
    for (int i = 0; i < 60; i++) begin
      frame();
      check_bounds("up_run");
    end
    check("top_clamp", {22'd0, pad_t}, 0);

    // down hold into the bottom edge
    set_btn(0, 1);
    for (int i = 0; i < 110; i++) begin
      frame();
      check_bounds("dn_run");
    end
    check("bot_clamp_t", {22'd0, pad_t}, 400);
    check("bot_clamp_b", {22'd0, pad_b}, 479);

    // both pressed holds
    set_btn(1, 1);
    for (int i = 0; i < 5; i++) begin
      frame();
      check("both_hold", {22'd0, pad_t}, 400);
    end

    // asynchronous reset while held
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_t", {22'd0, pad_t}, 200);
    m_y = 200; run_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    frame();
    check_bounds("after_rst");
    set_btn(0, 0);

    // randomized segments against the model
    for (int seg = 0; seg < 30; seg++) begin
      u = int'($urandom_range(0, 1));
      d = int'($urandom_range(0, 1));
      set_btn(u, d);
      nf = int'($urandom_range(1, 8));
      for (int f = 0; f < nf; f++) begin
        frame();
        check_bounds("rand");
      end
      for (int k = 0; k < 2; k++) begin
        px = int'($urandom_range(10, 40));
        py = m_y + int'($urandom_range(0, 90)) - 5;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        pon("rand_on", px, py);
      end
    end

    // long straight run from the reset position
    do_reset();
    set_btn(0, 1);
    repeat (17) frame();
`ifdef PAD_ACCEL_EN
    check("accel_17", {22'd0, pad_t}, 278);
    set_btn(0, 0);
    set_btn(0, 1);
    frame();
    check("accel_restart", {22'd0, pad_t}, 282);
`else
    check("flat_17", {22'd0, pad_t}, 268);
`endif
    check_bounds("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
